// File: rtl/chip8_framebuffer_pkg.sv
// rtl/chip8_framebuffer_pkg.sv - shared constants, FSM states and address helper for the CHIP-8 framebuffer
package chip8_framebuffer_pkg;

    localparam int SCR_W     = 64;
    localparam int SCR_H     = 32;
    localparam int FB_BYTES  = 256;
    localparam int ROW_BYTES = SCR_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        RD_LO,
        WR_LO,
        RD_HI,
        WR_HI,
        DONE
    } fb_state_e;

    // Eight bytes per 64-pixel row, so the byte address is simply {row, column byte}.
    function automatic logic [7:0] fb_byte_addr(input logic [4:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chip8_framebuffer_if.sv
// rtl/chip8_framebuffer_if.sv - sprite row fetch handshake between framebuffer and sprite memory
interface chip8_framebuffer_if;

    logic       spr_req;
    logic [3:0] spr_idx;
    logic       spr_ack;
    logic [7:0] spr_data;

    modport master (
        output spr_req,
        output spr_idx,
        input  spr_ack,
        input  spr_data
    );

    modport slave (
        input  spr_req,
        input  spr_idx,
        output spr_ack,
        output spr_data
    );

endinterface

// File: rtl/chip8_fb_ram.sv
// rtl/chip8_fb_ram.sv - 256x8 pixel store, one write port and two registered read ports
module chip8_fb_ram
    import chip8_framebuffer_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr_a,
    output logic [7:0] rdata_a,
    input  logic [7:0] raddr_b,
    output logic [7:0] rdata_b
);

    logic [7:0] mem [FB_BYTES];
    logic [7:0] rdata_a_q;
    logic [7:0] rdata_b_q;

    // Reads sample the array before this edge's write lands, so same-byte collisions return old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a_q <= mem[raddr_a];
        rdata_b_q <= mem[raddr_b];
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

endmodule

// File: rtl/chip8_framebuffer.sv
// rtl/chip8_framebuffer.sv - CHIP-8 64x32 monochrome framebuffer with CLS and XOR sprite draw engine
module chip8_framebuffer
    import chip8_framebuffer_pkg::*;
(
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [10:0]                 screen_adr,
    output logic                        screen_data,
    input  logic                        clear_start,
    input  logic                        draw_start,
    input  logic [5:0]                  draw_x,
    input  logic [4:0]                  draw_y,
    input  logic [3:0]                  draw_n,
    chip8_framebuffer_if.master         spr,
    output logic                        busy,
    output logic                        done,
    output logic                        collision
);

    fb_state_e  state_q, state_d;
    logic [7:0] clr_cnt_q, clr_cnt_d;
    logic [5:0] x_q, x_d;
    logic [4:0] y_q, y_d;
    logic [3:0] n_q, n_d;
    logic [3:0] row_q, row_d;
    logic [7:0] spr_q, spr_d;
    logic       coll_q, coll_d;
    logic [2:0] pix_sel_q, pix_sel_d;

    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_raddr_a;
    logic [7:0] ram_rdata_a;
    logic [7:0] ram_rdata_b;

    logic [4:0] tgt_row;
    logic [2:0] col_lo;
    logic [2:0] col_hi;
    logic [2:0] shift;
    logic [7:0] lo_bits;
    logic [7:0] hi_bits;
    logic       last_row;

    chip8_fb_ram u_ram (
        .clk     (CLOCK_50),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (ram_raddr_a),
        .rdata_a (ram_rdata_a),
        .raddr_b (screen_adr[10:3]),
        .rdata_b (ram_rdata_b)
    );

    // Sprite geometry: rows wrap mod 32 via 5-bit add, the hi column wraps mod 8 via 3-bit add.
    always_comb begin
        tgt_row  = y_q + {1'b0, row_q};
        col_lo   = x_q[5:3];
        col_hi   = col_lo + 3'd1;
        shift    = x_q[2:0];
        lo_bits  = spr_q >> shift;
        hi_bits  = spr_q << (4'd8 - {1'b0, shift});
        last_row = (row_q == (n_q - 4'd1));
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        row_d       = row_q;
        spr_d       = spr_q;
        coll_d      = coll_q;
        pix_sel_d   = screen_adr[2:0];
        ram_we      = 1'b0;
        ram_waddr   = 8'd0;
        ram_wdata   = 8'd0;
        ram_raddr_a = fb_byte_addr(tgt_row, (state_q == RD_HI) ? col_hi : col_lo);

        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    clr_cnt_d = 8'd0;
                    state_d   = CLEAR;
                end else if (draw_start) begin
                    x_d     = draw_x;
                    y_d     = draw_y;
                    n_d     = draw_n;
                    row_d   = 4'd0;
                    coll_d  = 1'b0;
                    state_d = (draw_n == 4'd0) ? DONE : FETCH;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = 8'h00;
                clr_cnt_d = clr_cnt_q + 8'd1;
                if (clr_cnt_q == 8'hFF) begin
                    state_d = DONE;
                end
            end
            FETCH: begin
                if (spr.spr_ack) begin
                    spr_d   = spr.spr_data;
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                state_d = WR_LO;
            end
            WR_LO: begin
                ram_we    = 1'b1;
                ram_waddr = fb_byte_addr(tgt_row, col_lo);
                ram_wdata = ram_rdata_a ^ lo_bits;
                if ((ram_rdata_a & lo_bits) != 8'd0) begin
                    coll_d = 1'b1;
                end
                if (shift != 3'd0) begin
                    state_d = RD_HI;
                end else if (last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = FETCH;
                end
            end
            RD_HI: begin
                state_d = WR_HI;
            end
            WR_HI: begin
                ram_we    = 1'b1;
                ram_waddr = fb_byte_addr(tgt_row, col_hi);
                ram_wdata = ram_rdata_a ^ hi_bits;
                if ((ram_rdata_a & hi_bits) != 8'd0) begin
                    coll_d = 1'b1;
                end
                if (last_row) begin
                    state_d = DONE;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset lands in CLEAR so the screen is wiped without any outside help.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= 8'd0;
            x_q       <= 6'd0;
            y_q       <= 5'd0;
            n_q       <= 4'd0;
            row_q     <= 4'd0;
            spr_q     <= 8'd0;
            coll_q    <= 1'b0;
            pix_sel_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            n_q       <= n_d;
            row_q     <= row_d;
            spr_q     <= spr_d;
            coll_q    <= coll_d;
            pix_sel_q <= pix_sel_d;
        end
    end

    assign screen_data  = ram_rdata_b[3'd7 - pix_sel_q];
    assign spr.spr_req  = (state_q == FETCH);
    assign spr.spr_idx  = row_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign collision    = coll_q;

endmodule

// File: tb/tb_chip8_framebuffer.sv
// tb/tb_chip8_framebuffer.sv - directed self-checking bench for chip8_framebuffer
module tb_chip8_framebuffer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [10:0] screen_adr;
    logic        screen_data;
    logic        clear_start;
    logic        draw_start;
    logic [5:0]  draw_x;
    logic [4:0]  draw_y;
    logic [3:0]  draw_n;
    logic        busy;
    logic        done;
    logic        collision;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    chip8_framebuffer_if spr_bus ();

    chip8_framebuffer dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .screen_adr  (screen_adr),
        .screen_data (screen_data),
        .clear_start (clear_start),
        .draw_start  (draw_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_n      (draw_n),
        .spr         (spr_bus),
        .busy        (busy),
        .done        (done),
        .collision   (collision)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_pix(input int x, input int y, output logic v);
        screen_adr = 11'(y * 64 + x);
        tick();
        v = screen_data;
    endtask

    task automatic check_pix(input string tag, input int x, input int y, input logic exp);
        logic v;
        rd_pix(x, y, v);
        expect_eq(tag, {31'd0, v}, {31'd0, exp});
    endtask

    task automatic wait_done(input string tag, input int budget, inout int lat);
        int w;
        w = 0;
        while (done !== 1'b1 && w < budget) begin
            tick();
            lat++;
            w++;
        end
        expect_eq(tag, {31'd0, done}, 32'd1);
    endtask

    // Drives one draw and answers each row request after ack_dly cycles of spr_req.
    task automatic run_draw(input logic [5:0] x, input logic [4:0] y, input logic [3:0] n,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input int ack_dly, output int lat);
        int w;
        draw_x = x; draw_y = y; draw_n = n;
        draw_start = 1'b1;
        tick();
        draw_start = 1'b0;
        lat = 1;
        for (int r = 0; r < int'(n); r++) begin
            w = 0;
            while (spr_bus.spr_req !== 1'b1 && w < 50) begin
                tick(); lat++; w++;
            end
            expect_eq("spr_idx", {28'd0, spr_bus.spr_idx}, r);
            for (int k = 1; k < ack_dly; k++) begin
                tick(); lat++;
            end
            spr_bus.spr_ack  = 1'b1;
            spr_bus.spr_data = (r == 0) ? b0 : b1;
            tick(); lat++;
            spr_bus.spr_ack  = 1'b0;
            expect_eq("spr_req_drop", {31'd0, spr_bus.spr_req}, 32'd0);
        end
        wait_done("draw_done", 50, lat);
        tick();
    endtask

    initial begin
        int   lat;
        int   cnt;
        int   base;
        int   reqs;
        logic v;

        reset = 1'b1; clear_start = 1'b0; draw_start = 1'b0;
        draw_x = '0; draw_y = '0; draw_n = '0; screen_adr = '0;
        spr_bus.spr_ack = 1'b0; spr_bus.spr_data = 8'h00;

        // Power-on: reset, 256 busy clearing cycles, one done, blank screen
        tick(); tick();
        expect_eq("rst_spr_req", {31'd0, spr_bus.spr_req}, 32'd0);
        expect_eq("rst_collision", {31'd0, collision}, 32'd0);
        expect_eq("rst_done", {31'd0, done}, 32'd0);
        base = done_cnt;
        reset = 1'b0;
        cnt = 0;
        while (done !== 1'b1 && cnt < 400) begin
            if (busy === 1'b1) cnt++;
            tick();
        end
        expect_eq("clear_busy_cycles", cnt, 256);
        tick();
        expect_eq("busy_after_clear", {31'd0, busy}, 32'd0);
        cnt = 0;
        for (int a = 0; a < 2048; a++) begin
            screen_adr = 11'(a);
            tick();
            if (screen_data !== 1'b0) cnt++;
        end
        expect_eq("nonzero_pixels", cnt, 0);
        expect_eq("done_pulses", done_cnt - base, 1);

        // Byte-aligned single row: ack on third fetch cycle, done at cycle 6
        run_draw(6'd0, 5'd0, 4'd1, 8'hF0, 8'h00, 3, lat);
        expect_eq("aligned_latency", lat, 6);
        expect_eq("aligned_coll", {31'd0, collision}, 32'd0);
        check_pix("px0", 0, 0, 1'b1);
        check_pix("px3", 3, 0, 1'b1);
        check_pix("px4", 4, 0, 1'b0);

        // Same sprite again erases it and flags collision
        run_draw(6'd0, 5'd0, 4'd1, 8'hF0, 8'h00, 3, lat);
        expect_eq("redraw_coll", {31'd0, collision}, 32'd1);
        check_pix("redraw_px0", 0, 0, 1'b0);
        check_pix("redraw_px3", 3, 0, 1'b0);
        repeat (5) tick();
        expect_eq("coll_held", {31'd0, collision}, 32'd1);

        // Wrap in both axes: x=62, y=31, two rows
        run_draw(6'd62, 5'd31, 4'd2, 8'hFF, 8'h81, 1, lat);
        expect_eq("wrap_latency", lat, 11);
        expect_eq("wrap_coll", {31'd0, collision}, 32'd0);
        check_pix("r31_px61", 61, 31, 1'b0);
        check_pix("r31_px62", 62, 31, 1'b1);
        check_pix("r31_px63", 63, 31, 1'b1);
        check_pix("r31_px0", 0, 31, 1'b1);
        check_pix("r31_px5", 5, 31, 1'b1);
        check_pix("r31_px6", 6, 31, 1'b0);
        check_pix("r0_px62", 62, 0, 1'b1);
        check_pix("r0_px63", 63, 0, 1'b0);
        check_pix("r0_px5", 5, 0, 1'b1);
        check_pix("r0_px4", 4, 0, 1'b0);

        // Zero-row draw goes straight to done
        run_draw(6'd0, 5'd0, 4'd0, 8'h00, 8'h00, 1, lat);
        expect_eq("n0_latency", lat, 1);

        // Clear beats draw in the same cycle; draw while busy is dropped
        draw_x = 6'd10; draw_y = 5'd3; draw_n = 4'd1;
        clear_start = 1'b1; draw_start = 1'b1;
        tick();
        clear_start = 1'b0; draw_start = 1'b0;
        cnt = 1; reqs = 0;
        while (done !== 1'b1 && cnt < 400) begin
            if (spr_bus.spr_req === 1'b1) reqs++;
            draw_start = (cnt == 10);
            tick();
            cnt++;
        end
        draw_start = 1'b0;
        expect_eq("cls_win_latency", cnt, 257);
        expect_eq("cls_win_reqs", reqs, 0);
        tick(); tick();
        expect_eq("cls_win_idle", {31'd0, busy}, 32'd0);
        expect_eq("cls_win_no_req", {31'd0, spr_bus.spr_req}, 32'd0);
        check_pix("cls_px62_r31", 62, 31, 1'b0);
        check_pix("cls_px10_r3", 10, 3, 1'b0);

        // Reset in the middle of a draw with a late ack
        run_draw(6'd8, 5'd4, 4'd1, 8'hAA, 8'h00, 2, lat);
        check_pix("pre_rst_px8", 8, 4, 1'b1);
        check_pix("pre_rst_px9", 9, 4, 1'b0);
        draw_x = 6'd0; draw_y = 5'd0; draw_n = 4'd3;
        draw_start = 1'b1;
        tick();
        draw_start = 1'b0;
        tick();
        expect_eq("mid_req_high", {31'd0, spr_bus.spr_req}, 32'd1);
        reset = 1'b1;
        spr_bus.spr_ack = 1'b1; spr_bus.spr_data = 8'hFF;
        tick();
        reset = 1'b0;
        expect_eq("mid_rst_req", {31'd0, spr_bus.spr_req}, 32'd0);
        expect_eq("mid_rst_busy", {31'd0, busy}, 32'd1);
        tick();
        spr_bus.spr_ack = 1'b0;
        lat = 0;
        wait_done("mid_rst_done", 400, lat);
        tick();
        expect_eq("mid_rst_idle", {31'd0, busy}, 32'd0);
        expect_eq("mid_rst_no_req", {31'd0, spr_bus.spr_req}, 32'd0);
        check_pix("post_rst_px8", 8, 4, 1'b0);
        check_pix("post_rst_px0", 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
